// File: rtl/tf_pkg.sv
// Shared constants and loader state encoding for the twiddle-factor buffer write path.
// Pure declarations, no latency and no flow control of its own.
package tf_pkg;
   localparam int TF_ADDR_WIDTH = 13;
   localparam int TF_DATA_WIDTH = 216;
   localparam int TF_DP         = 256;
   localparam int TF_BANKS      = TF_DP / 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } tf_ld_state_t;
endpackage

// File: rtl/tf_stage_row.sv
// Staging row: BANKS x DATA_WIDTH registers, one indexed write per cycle, flat parallel read.
// Write lands one cycle after wr_en; no backpressure, the caller owns sequencing.
module tf_stage_row #(
   parameter int BANKS      = 4,
   parameter int DATA_WIDTH = 16,
   parameter int IDX_W      = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        wr_en,
   input  logic [IDX_W-1:0]            wr_idx,
   input  logic [DATA_WIDTH-1:0]       wr_dat,
   output logic [BANKS*DATA_WIDTH-1:0] rd_flat
);
   logic [DATA_WIDTH-1:0] slot_q [BANKS];
   logic [DATA_WIDTH-1:0] slot_d [BANKS];

   always_comb begin
      slot_d = slot_q;
      if (wr_en) begin
         slot_d[wr_idx] = wr_dat;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BANKS; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         slot_q <= slot_d;
      end
   end

   for (genvar g = 0; g < BANKS; g++) begin : g_rd
      assign rd_flat[g*DATA_WIDTH +: DATA_WIDTH] = slot_q[g];
   end
endmodule

// File: rtl/tf_loader.sv
// Twiddle buffer loader: packs DP/2 stream words per row, then one shared-we write at base+row.
// we follows the last lane handshake by one cycle; s_ready only in FILL, upstream stalls otherwise.
module tf_loader
   import tf_pkg::*;
#(
   parameter int ADDR_WIDTH = TF_ADDR_WIDTH,
   parameter int DATA_WIDTH = TF_DATA_WIDTH,
   parameter int DP         = TF_DP
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic [ADDR_WIDTH-1:0]          base_addr,
   input  logic [ADDR_WIDTH:0]            num_rows,
   input  logic                           s_valid,
   input  logic [DATA_WIDTH-1:0]          s_data,
   output logic                           s_ready,
   output logic [DP/2*ADDR_WIDTH-1:0]     addr,
   output logic [DP/2*DATA_WIDTH-1:0]     data_out,
   output logic                           we,
   output logic                           busy,
   output logic                           done
);
   localparam int BANKS  = DP / 2;
   localparam int LANE_W = (BANKS > 1) ? $clog2(BANKS) : 1;
   localparam logic [LANE_W-1:0]   LANE_LAST = LANE_W'(BANKS - 1);
   localparam logic [LANE_W-1:0]   LANE_ONE  = LANE_W'(1);
   localparam logic [ADDR_WIDTH:0] ROW_ONE   = (ADDR_WIDTH+1)'(1);

   tf_ld_state_t state_q, state_d;
   logic [LANE_W-1:0]        lane_q, lane_d;
   logic [ADDR_WIDTH:0]      row_q, row_d;
   logic [ADDR_WIDTH:0]      nrows_q, nrows_d;
   logic [ADDR_WIDTH-1:0]    base_q, base_d;
   logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
   logic [BANKS*DATA_WIDTH-1:0] data_q, data_d;
   logic we_q, we_d;
   logic busy_q, busy_d;
   logic done_q, done_d;

   logic                        hs;
   logic [BANKS*DATA_WIDTH-1:0] stage_flat;

   assign s_ready = (state_q == ST_FILL);
   assign hs      = s_valid && s_ready;

   tf_stage_row #(
      .BANKS      (BANKS),
      .DATA_WIDTH (DATA_WIDTH),
      .IDX_W      (LANE_W)
   ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (hs),
      .wr_idx  (lane_q),
      .wr_dat  (s_data),
      .rd_flat (stage_flat)
   );

   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      row_d   = row_q;
      nrows_d = nrows_q;
      base_d  = base_q;
      addr_d  = addr_q;
      data_d  = data_q;
      we_d    = 1'b0;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               base_d  = base_addr;
               nrows_d = num_rows;
               lane_d  = '0;
               row_d   = '0;
               busy_d  = 1'b1;
               if (num_rows != '0) begin
                  state_d = ST_FILL;
               end else begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end
            end
         end
         ST_FILL: begin
            if (hs) begin
               lane_d = lane_q + LANE_ONE;
               if (lane_q == LANE_LAST) begin
                  lane_d  = '0;
                  state_d = ST_WRITE;
                  we_d    = 1'b1;
                  addr_d  = base_q + row_q[ADDR_WIDTH-1:0];
                  // The last word is still in flight to the staging row, so splice it in here.
                  data_d  = stage_flat;
                  data_d[(BANKS-1)*DATA_WIDTH +: DATA_WIDTH] = s_data;
               end
            end
         end
         ST_WRITE: begin
            if (row_q == nrows_q - ROW_ONE) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else begin
               row_d   = row_q + ROW_ONE;
               state_d = ST_FILL;
            end
         end
         ST_DONE: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         lane_q  <= '0;
         row_q   <= '0;
         nrows_q <= '0;
         base_q  <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
         row_q   <= row_d;
         nrows_q <= nrows_d;
         base_q  <= base_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         we_q    <= we_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign addr     = {BANKS{addr_q}};
   assign data_out = data_q;
   assign we       = we_q;
   assign busy     = busy_q;
   assign done     = done_q;
endmodule

// File: tb/tb_tf_loader.sv
// Directed bench for tf_loader at 4 banks x 16 bits, 4-bit row addresses.
module tb_tf_loader;
   localparam int AW = 4;
   localparam int DW = 16;
   localparam int DP = 8;
   localparam int NB = DP / 2;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [AW-1:0]     base_addr;
   logic [AW:0]       num_rows;
   logic              s_valid;
   logic [DW-1:0]     s_data;
   logic              s_ready;
   logic [NB*AW-1:0]  addr;
   logic [NB*DW-1:0]  data_out;
   logic              we;
   logic              busy;
   logic              done;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int ready_cnt = 0;

   logic [NB*AW-1:0] we_addr_q [$];
   logic [NB*DW-1:0] we_data_q [$];
   int               we_cyc_q  [$];
   int               done_cyc_q[$];

   tf_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DP(DP)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .num_rows  (num_rows),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_ready   (s_ready),
      .addr      (addr),
      .data_out  (data_out),
      .we        (we),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n) begin
         if (we) begin
            we_addr_q.push_back(addr);
            we_data_q.push_back(data_out);
            we_cyc_q.push_back(cyc);
         end
         if (done) done_cyc_q.push_back(cyc);
         if (s_ready) ready_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [NB*DW-1:0] row_exp(input logic [DW-1:0] first, input int r);
      logic [NB*DW-1:0] v;
      for (int i = 0; i < NB; i++) v[i*DW +: DW] = first + DW'(r*NB + i);
      return v;
   endfunction

   function automatic logic [NB*AW-1:0] addr_exp(input int a);
      logic [AW-1:0] s;
      s = AW'(a);
      return {NB{s}};
   endfunction

   task automatic clear_log();
      we_addr_q.delete();
      we_data_q.delete();
      we_cyc_q.delete();
      done_cyc_q.delete();
      ready_cnt = 0;
   endtask

   task automatic start_job(input int b, input int n);
      start = 1'b1;
      base_addr = AW'(b);
      num_rows  = (AW+1)'(n);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_words(input int n, input logic [DW-1:0] first, input bit toggle);
      bit acc;
      bit got;
      int budget;
      for (int k = 0; k < n; k++) begin
         s_valid = 1'b1;
         s_data  = first + DW'(k);
         got = 1'b0;
         budget = 0;
         while (!got) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk); #1;
            if (acc) got = 1'b1;
            else if (++budget > 200) begin
               chk("send_timeout", 64'd0, 64'd1);
               got = 1'b1;
            end
         end
         if (toggle) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
         end
      end
      s_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n0;
      int b;
      n0 = done_cyc_q.size();
      b = 0;
      while (done_cyc_q.size() == n0 && b < budget) begin
         @(posedge clk); #1;
         b++;
      end
      if (done_cyc_q.size() == n0) chk("done_timeout", 64'd0, 64'd1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; base_addr = '0; num_rows = '0;
      s_valid = 1'b0; s_data = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_s_ready", 64'(s_ready), 64'd0);
      chk("rst_we", 64'(we), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_addr", 64'(addr), 64'd0);
      chk("rst_data", 64'(data_out), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: single row
      clear_log();
      start_job(2, 1);
      chk("t1_busy", 64'(busy), 64'd1);
      send_words(4, 16'h00A0, 1'b0);
      wait_done(50);
      chk("t1_we_cnt", 64'(we_cyc_q.size()), 64'd1);
      if (we_cyc_q.size() == 1) begin
         chk("t1_addr", 64'(we_addr_q[0]), 64'(addr_exp(2)));
         chk("t1_data", 64'(we_data_q[0]), 64'h00A3_00A2_00A1_00A0);
      end
      chk("t1_done_cnt", 64'(done_cyc_q.size()), 64'd1);
      if (done_cyc_q.size() == 1 && we_cyc_q.size() == 1)
         chk("t1_done_lat", 64'(done_cyc_q[0] - we_cyc_q[0]), 64'd1);
      chk("t1_busy_end", 64'(busy), 64'd0);
      chk("t1_hold_data", 64'(data_out), 64'h00A3_00A2_00A1_00A0);

      // 2: three rows with address wrap
      clear_log();
      start_job(14, 3);
      send_words(12, 16'h0100, 1'b0);
      wait_done(100);
      chk("t2_we_cnt", 64'(we_cyc_q.size()), 64'd3);
      if (we_cyc_q.size() == 3) begin
         chk("t2_addr0", 64'(we_addr_q[0]), 64'(addr_exp(14)));
         chk("t2_addr1", 64'(we_addr_q[1]), 64'(addr_exp(15)));
         chk("t2_addr2", 64'(we_addr_q[2]), 64'(addr_exp(0)));
         for (int r = 0; r < 3; r++) chk("t2_data", 64'(we_data_q[r]), 64'(row_exp(16'h0100, r)));
         chk("t2_gap01", 64'(we_cyc_q[1] - we_cyc_q[0]), 64'd5);
         chk("t2_gap12", 64'(we_cyc_q[2] - we_cyc_q[1]), 64'd5);
         if (done_cyc_q.size() == 1) chk("t2_done_lat", 64'(done_cyc_q[0] - we_cyc_q[2]), 64'd1);
      end
      chk("t2_done_cnt", 64'(done_cyc_q.size()), 64'd1);

      // 3: s_valid toggling
      clear_log();
      start_job(5, 2);
      send_words(8, 16'h0200, 1'b1);
      wait_done(100);
      chk("t3_we_cnt", 64'(we_cyc_q.size()), 64'd2);
      if (we_cyc_q.size() == 2) begin
         chk("t3_addr0", 64'(we_addr_q[0]), 64'(addr_exp(5)));
         chk("t3_addr1", 64'(we_addr_q[1]), 64'(addr_exp(6)));
         chk("t3_data0", 64'(we_data_q[0]), 64'(row_exp(16'h0200, 0)));
         chk("t3_data1", 64'(we_data_q[1]), 64'(row_exp(16'h0200, 1)));
      end

      // 4: zero-row job
      clear_log();
      start_job(3, 0);
      wait_done(20);
      chk("t4_done_cnt", 64'(done_cyc_q.size()), 64'd1);
      chk("t4_we_cnt", 64'(we_cyc_q.size()), 64'd0);
      chk("t4_ready_cnt", 64'(ready_cnt), 64'd0);
      chk("t4_busy_end", 64'(busy), 64'd0);

      // 5: reset mid-row, then a fresh job
      clear_log();
      start_job(3, 1);
      send_words(2, 16'h0300, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("t5_we", 64'(we), 64'd0);
      chk("t5_busy", 64'(busy), 64'd0);
      chk("t5_ready", 64'(s_ready), 64'd0);
      chk("t5_done", 64'(done), 64'd0);
      chk("t5_data", 64'(data_out), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("t5_no_we", 64'(we_cyc_q.size()), 64'd0);
      chk("t5_no_done", 64'(done_cyc_q.size()), 64'd0);
      start_job(7, 1);
      send_words(4, 16'h0400, 1'b0);
      wait_done(50);
      chk("t5_we_cnt", 64'(we_cyc_q.size()), 64'd1);
      if (we_cyc_q.size() == 1) begin
         chk("t5_addr", 64'(we_addr_q[0]), 64'(addr_exp(7)));
         chk("t5_data_new", 64'(we_data_q[0]), 64'(row_exp(16'h0400, 0)));
      end

      // 6: start pulses during FILL and WRITE must be ignored
      clear_log();
      start_job(9, 2);
      fork
         send_words(8, 16'h0500, 1'b0);
         begin
            int b;
            repeat (2) @(posedge clk);
            #1;
            start = 1'b1; base_addr = '0; num_rows = 5'd5;
            @(posedge clk); #1;
            start = 1'b0;
            b = 0;
            while (!we && b < 50) begin
               @(negedge clk);
               b++;
            end
            if (!we) chk("t6_we_timeout", 64'd0, 64'd1);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
         end
      join
      wait_done(100);
      repeat (20) @(posedge clk);
      #1;
      chk("t6_we_cnt", 64'(we_cyc_q.size()), 64'd2);
      if (we_cyc_q.size() == 2) begin
         chk("t6_addr0", 64'(we_addr_q[0]), 64'(addr_exp(9)));
         chk("t6_addr1", 64'(we_addr_q[1]), 64'(addr_exp(10)));
         chk("t6_data1", 64'(we_data_q[1]), 64'(row_exp(16'h0500, 1)));
      end
      chk("t6_done_cnt", 64'(done_cyc_q.size()), 64'd1);
      chk("t6_busy_end", 64'(busy), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
